state_mem_arbiter: RTL and testbench
====================================

STATE_MEM_ARBITER -- requirements
Module: state_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of ALU requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning stateful-RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, meaning stateful-RAM address width (32 words).
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port req_op  input  2*NUM_REQ  per-requester op (01 LOAD, 10 STORE, 11 LOADD, 00 NOP).
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH*NUM_REQ  tenant-relative address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH*NUM_REQ  STORE data.
REQ-011 SHALL have port req_page  input  16*NUM_REQ  page-table entry {addr_len[15:8], base_addr[7:0]}.
REQ-012 SHALL have port resp_valid  output  NUM_REQ  per-requester response valid.
REQ-013 SHALL have port resp_ready  input  NUM_REQ  per-requester response accept.
REQ-014 SHALL have port resp_data  output  DATA_WIDTH  response data, shared bus, qualified by resp_valid.
REQ-015 SHALL have port resp_overflow  output  1  address exceeded addr_len; qualified by resp_valid.
REQ-016 SHALL have port ram_addr  output  ADDR_WIDTH  RAM address.
REQ-017 SHALL have port ram_we  output  1  RAM write enable.
REQ-018 SHALL have port ram_din  output  DATA_WIDTH  RAM write data.
REQ-019 SHALL have port ram_dout  input  DATA_WIDTH  RAM read data, valid one cycle after ram_addr.

Function
REQ-020 SHALL serve one transaction at a time via FSM states IDLE, READ, DATA, WRITE, RESP.
REQ-021 IDLE SHALL grant round-robin, starting at index after last granted, asserting req_ready[w] for exactly one cycle; transfer = req_valid&req_ready.
REQ-022 On accept SHALL latch id, op, addr, wdata, page; overflow = (addr > addr_len, unsigned 8-bit compare).
REQ-023 Physical address SHALL be (base_addr + addr) mod 2^ADDR_WIDTH.
REQ-024 Next state from IDLE: overflow or NOP -> RESP; STORE -> WRITE; LOAD/LOADD -> READ.
REQ-025 READ SHALL drive ram_addr=phys, ram_we=0, -> DATA; DATA SHALL capture ram_dout; LOAD -> RESP, LOADD -> WRITE.
REQ-026 WRITE SHALL assert ram_we for one cycle with ram_addr=phys; ram_din = wdata (STORE) or captured+1 mod 2^DATA_WIDTH (LOADD); -> RESP.
REQ-027 resp_data SHALL be: LOAD captured word; LOADD captured+1; STORE wdata; NOP or overflow 0.
REQ-028 RESP SHALL hold resp_valid[id], resp_data, resp_overflow stable until resp_ready[id]; then -> IDLE, same cycle no grant.
REQ-029 Latency accept(T) to resp_valid: overflow/NOP T+1, STORE T+2, LOAD T+3, LOADD T+4.
REQ-030 ram_we SHALL never assert for overflow, NOP or LOAD transactions.
REQ-031 req_ready SHALL be 0 outside IDLE; simultaneous requests wait without loss.
REQ-032 LOADD read-modify-write SHALL be atomic: no other transaction interleaves.

Reset
REQ-033 On rst_n=0: state IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_overflow=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-034 Round-robin pointer SHALL reset so requester 0 has highest priority.
REQ-035 Reset mid-transaction SHALL discard it with no RAM write and no response.

Structure
REQ-036 Op encodings and FSM state encodings SHALL reside in shared package rmt_state_pkg.
REQ-037 Round-robin grant logic SHALL be sub-module rr_arbiter (NUM_REQ parameter, req in, one-hot grant out, advance input).

Verification
REQ-038 Req1 STORE addr=3 wdata=0xDEADBEEF page={len=8,base=4} -> ram_we at T+1 addr=7; resp_valid[1] at T+2, data=0xDEADBEEF, overflow=0.
REQ-039 Word 7=0xFFFFFFFF, req0 LOADD addr=3 base=4 -> RAM writes 0 at T+3; resp data=0 at T+4.
REQ-040 Req2 LOAD addr=9 len=8 -> resp at T+1, overflow=1, data=0, no ram_we.
REQ-041 All four requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0.
REQ-042 base=30 addr=5 len=8 STORE -> ram_addr=3 (wrap).
REQ-043 rst_n low during LOADD DATA state -> no ram_we, no resp_valid; next grant to requester 0.

Source files
------------

// File: rtl/rmt_state_pkg.sv
// Shared definitions for the stateful-memory arbiter.
// Holds the ALU op encodings, the arbiter FSM state encoding, the page-table
// entry width and a helper that decides whether an access exceeds its page.
package rmt_state_pkg;

    // The ALU op codes that arrive on req_op.
    typedef enum logic [1:0] {
        OpNop   = 2'b00,
        OpLoad  = 2'b01,
        OpStore = 2'b10,
        OpLoadd = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StData  = 3'd2,
        StWrite = 3'd3,
        StResp  = 3'd4
    } state_e;

    // A page-table entry is {addr_len[15:8], base_addr[7:0]}.
    localparam int unsigned PageWidth = 16;

    // The address is relative to the tenant page. Any address strictly above
    // addr_len is outside the page.
    function automatic logic page_overflow(input logic [7:0] addr, input logic [PageWidth-1:0] page);
        return addr > page[15:8];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant for the stateful-memory arbiter.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   i_req       per-requester request
//   i_advance   the current grant was taken, so move the priority past it
//   o_grant     one-hot grant, or zero when nobody requests
// Priority starts at the index after the last advanced grant. After reset,
// requester 0 has top priority.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int unsigned IdWidth = $clog2(NUM_REQ);

    logic [IdWidth-1:0] r_last;
    logic [IdWidth-1:0] w_grant_idx;
    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_req_hi;

    // Requesters above the last winner get first pick. The lowest set bit of
    // that group wins. When the group is empty, the search wraps to the
    // lowest requester overall.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_mask[i] = (i > int'(r_last));
        end
    end

    assign w_req_hi = i_req & w_mask;
    assign o_grant  = (|w_req_hi) ? (w_req_hi & (-w_req_hi)) : (i_req & (-i_req));

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_grant[i]) begin
                w_grant_idx = IdWidth'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= IdWidth'(NUM_REQ - 1);
        end else if (i_advance) begin
            r_last <= w_grant_idx;
        end
    end

endmodule

// File: rtl/state_mem_arbiter.sv
// Stateful-RAM arbiter. Several ALU requesters share one single-port RAM.
// It serves one transaction at a time, and a LOADD read-modify-write is never
// split by another transaction.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (ready is one-hot)
//   req_op/addr/wdata/page     per-requester packed request fields
//   resp_valid/resp_ready      per-requester response handshake
//   resp_data, resp_overflow   shared response bus, qualified by resp_valid
//   ram_addr/we/din, ram_dout  RAM port; read data arrives one cycle after ram_addr
module state_mem_arbiter
    import rmt_state_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [2*NUM_REQ-1:0]            req_op,
    input  logic [ADDR_WIDTH*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]   req_wdata,
    input  logic [PageWidth*NUM_REQ-1:0]    req_page,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [DATA_WIDTH-1:0]           resp_data,
    output logic                            resp_overflow,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic                            ram_we,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout
);

    localparam int unsigned IdWidth = $clog2(NUM_REQ);

    state_e                r_state;
    state_e                w_state_next;
    logic [IdWidth-1:0]    r_id;
    op_e                   r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_base;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_accept;
    logic [IdWidth-1:0]    w_sel_id;
    op_e                   w_sel_op;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [PageWidth-1:0]  w_sel_page;
    logic                  w_sel_overflow;
    logic [ADDR_WIDTH-1:0] w_phys;
    logic [DATA_WIDTH-1:0] w_rmw;
    logic [DATA_WIDTH-1:0] w_result;
    logic [NUM_REQ-1:0]    w_id_onehot;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req_valid),
        .i_advance(w_accept),
        .o_grant  (w_grant)
    );

    // A grant is only offered in IDLE, and only to a valid requester, so the
    // offered grant and the transfer are the same event.
    assign w_accept = rst_n && (r_state == StIdle) && (|w_grant);

    // Select the granted requester's fields. The grant is one-hot, so at most
    // one loop iteration assigns.
    always_comb begin
        w_sel_id    = '0;
        w_sel_op    = OpNop;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_page  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_id    = IdWidth'(i);
                w_sel_op    = op_e'(req_op[2*i +: 2]);
                w_sel_addr  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
                w_sel_page  = req_page[PageWidth*i +: PageWidth];
            end
        end
    end

    assign w_sel_overflow = page_overflow(8'(w_sel_addr), w_sel_page);

    // The physical address wraps modulo the RAM size.
    assign w_phys = ADDR_WIDTH'(r_base) + r_addr;
    assign w_rmw  = r_rdata + DATA_WIDTH'(1);

    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_id_onehot[i] = (r_id == IdWidth'(i));
        end
    end

    always_comb begin
        w_result = '0;
        if (!r_overflow) begin
            case (r_op)
                OpLoad:  w_result = r_rdata;
                OpLoadd: w_result = w_rmw;
                OpStore: w_result = r_wdata;
                default: w_result = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id       <= '0;
            r_op       <= OpNop;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_base     <= '0;
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_id       <= w_sel_id;
                r_op       <= w_sel_op;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                r_base     <= w_sel_page[7:0];
                r_overflow <= w_sel_overflow;
            end
            if (r_state == StData) begin
                r_rdata <= ram_dout;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_sel_overflow || (w_sel_op == OpNop)) begin
                        w_state_next = StResp;
                    end else if (w_sel_op == OpStore) begin
                        w_state_next = StWrite;
                    end else begin
                        w_state_next = StRead;
                    end
                end
            end
            StRead:  w_state_next = StData;
            StData:  w_state_next = (r_op == OpLoadd) ? StWrite : StResp;
            StWrite: w_state_next = StResp;
            StResp: begin
                if (|(resp_ready & w_id_onehot)) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // All outputs are forced to zero while rst_n is low. This keeps an
    // interrupted transaction from writing RAM or responding during the
    // reset cycle.
    always_comb begin
        req_ready     = '0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_overflow = 1'b0;
        ram_addr      = '0;
        ram_we        = 1'b0;
        ram_din       = '0;
        if (rst_n) begin
            case (r_state)
                StIdle: req_ready = w_accept ? w_grant : '0;
                StRead: ram_addr = w_phys;
                StWrite: begin
                    ram_addr = w_phys;
                    ram_we   = 1'b1;
                    ram_din  = (r_op == OpLoadd) ? w_rmw : r_wdata;
                end
                StResp: begin
                    resp_valid    = w_id_onehot;
                    resp_data     = w_result;
                    resp_overflow = r_overflow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_state_mem_arbiter.sv
// Self-checking bench for state_mem_arbiter.
// A transaction-level model predicts the outputs on every cycle. It keeps a
// shadow memory, a round-robin pointer and a per-transaction latency table.
// Directed scenarios add hand-computed literal expectations.
module tb_state_mem_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] STORE = 2'b10;
    localparam logic [1:0] LOADD = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [AW*N-1:0] req_addr;
    logic [DW*N-1:0] req_wdata;
    logic [16*N-1:0] req_page;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [DW-1:0]   resp_data;
    logic            resp_overflow;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;
    logic [DW-1:0]   ram_din;
    logic [DW-1:0]   ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    state_mem_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_page     (req_page),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_overflow(resp_overflow),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency
    logic [DW-1:0] ram_q [32];
    always @(posedge clk) begin
        if (ram_we) ram_q[ram_addr] <= ram_din;
        ram_dout <= ram_q[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [32];
    bit            m_busy = 0;
    int            m_last = N - 1;
    int            m_c, m_lat, m_wc, m_id, m_phys;
    logic [1:0]    m_op;
    bit            m_ovf, m_wr, m_found;
    logic [DW-1:0] m_res, m_wval, m_rd;
    logic [N-1:0]  m_exp;
    int            m_a, m_len, m_base, m_j;

    always @(negedge clk) begin : model
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_overflow", resp_overflow, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_din", ram_din, 0);
            m_busy = 0;
            m_last = N - 1;
        end else if (!m_busy) begin
            m_exp   = '0;
            m_found = 0;
            m_j     = 0;
            for (int k = 1; k <= N; k++) begin
                if (!m_found && req_valid[(m_last + k) % N]) begin
                    m_j          = (m_last + k) % N;
                    m_exp[m_j]   = 1'b1;
                    m_found      = 1;
                end
            end
            chk("grant", req_ready, m_exp);
            chk("idle_resp_valid", resp_valid, 0);
            chk("idle_ram_we", ram_we, 0);
            if (m_found) begin
                m_id   = m_j;
                m_op   = req_op[2*m_j +: 2];
                m_a    = int'(req_addr[AW*m_j +: AW]);
                m_len  = int'(req_page[16*m_j+8 +: 8]);
                m_base = int'(req_page[16*m_j +: 8]);
                m_ovf  = (m_a > m_len);
                m_phys = (m_base + m_a) % 32;
                m_rd   = m_mem[m_phys];
                m_wr   = 0;
                m_wc   = 0;
                if (m_ovf || m_op == NOP) begin
                    m_lat = 1; m_res = 0;
                end else if (m_op == STORE) begin
                    m_lat = 2; m_wr = 1; m_wc = 1;
                    m_wval = req_wdata[DW*m_j +: DW];
                    m_res  = m_wval;
                end else if (m_op == LOAD) begin
                    m_lat = 3; m_res = m_rd;
                end else begin
                    m_lat = 4; m_wr = 1; m_wc = 3;
                    m_wval = m_rd + 1;
                    m_res  = m_wval;
                end
                m_busy = 1;
                m_c    = 1;
                m_last = m_j;
            end
        end else begin
            chk("busy_req_ready", req_ready, 0);
            chk("ram_we", ram_we, (m_wr && m_c == m_wc) ? 1 : 0);
            if (m_wr && m_c == m_wc) begin
                chk("wr_addr", ram_addr, m_phys);
                chk("wr_din", ram_din, m_wval);
                m_mem[m_phys] = m_wval;
            end
            if (m_c == 1 && !m_ovf && (m_op == LOAD || m_op == LOADD))
                chk("rd_addr", ram_addr, m_phys);
            if (m_c >= m_lat) begin
                chk("resp_valid", resp_valid, 1 << m_id);
                chk("resp_data", resp_data, m_res);
                chk("resp_overflow", resp_overflow, m_ovf);
                if (resp_ready[m_id]) m_busy = 0;
            end else begin
                chk("early_resp_valid", resp_valid, 0);
            end
            m_c++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic [1:0] op, input int addr,
                           input logic [DW-1:0] wdata, input int len, input int base);
        req_op[2*id +: 2]     = op;
        req_addr[AW*id +: AW] = AW'(addr);
        req_wdata[DW*id +: DW] = wdata;
        req_page[16*id +: 16] = {8'(len), 8'(base)};
    endtask

    // Raise one request, wait (bounded) for its accept, then drop it.
    // On return the time is just after the accept edge, inside cycle t+1.
    task automatic do_txn(input int id, input logic [1:0] op, input int addr,
                          input logic [DW-1:0] wdata, input int len, input int base,
                          output int t);
        bit got = 0;
        t = 0;
        @(posedge clk); #1;
        set_req(id, op, addr, wdata, len, base);
        req_valid[id] = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                t = cyc; got = 1; break;
            end
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: requester %0d got no ready, required within 50 cycles", id);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_neg(input int target);
        forever begin
            @(negedge clk);
            if (cyc >= target) break;
        end
    endtask

    int t;
    int order [5];
    int n_gr;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_page   = '0;
        resp_ready = '1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Req1 STORE addr 3, base 4 -> physical 7.
        do_txn(1, STORE, 3, 32'hDEADBEEF, 8, 4, t);
        wait_neg(t + 1);
        chk("st_we", ram_we, 1);
        chk("st_addr", ram_addr, 7);
        chk("st_din", ram_din, 32'hDEADBEEF);
        wait_neg(t + 2);
        chk("st_resp_valid", resp_valid, 4'b0010);
        chk("st_resp_data", resp_data, 32'hDEADBEEF);
        chk("st_resp_ovf", resp_overflow, 0);

        // The response must hold while resp_ready is low.
        @(posedge clk); #1 resp_ready = 4'b1101;
        do_txn(1, LOAD, 7, 0, 8, 0, t);
        wait_neg(t + 3);
        chk("hold_valid_a", resp_valid, 4'b0010);
        chk("hold_data_a", resp_data, 32'hDEADBEEF);
        wait_neg(t + 5);
        chk("hold_valid_b", resp_valid, 4'b0010);
        chk("hold_data_b", resp_data, 32'hDEADBEEF);
        @(posedge clk); #1 resp_ready = '1;
        wait_neg(t + 7);
        chk("hold_released", resp_valid, 0);

        // LOADD of 0xFFFFFFFF wraps to 0.
        do_txn(0, STORE, 3, 32'hFFFFFFFF, 8, 4, t);
        wait_neg(t + 2);
        do_txn(0, LOADD, 3, 0, 8, 4, t);
        wait_neg(t + 1);
        chk("ldd_rd_addr", ram_addr, 7);
        chk("ldd_rd_we", ram_we, 0);
        wait_neg(t + 3);
        chk("ldd_we", ram_we, 1);
        chk("ldd_addr", ram_addr, 7);
        chk("ldd_din", ram_din, 0);
        wait_neg(t + 4);
        chk("ldd_resp_valid", resp_valid, 4'b0001);
        chk("ldd_resp_data", resp_data, 0);

        // Overflow: addr 9 > len 8.
        do_txn(2, LOAD, 9, 0, 8, 0, t);
        wait_neg(t + 1);
        chk("ovf_resp_valid", resp_valid, 4'b0100);
        chk("ovf_flag", resp_overflow, 1);
        chk("ovf_data", resp_data, 0);
        chk("ovf_we", ram_we, 0);

        // Physical address wraps: base 30 + addr 5 -> 3.
        do_txn(3, STORE, 5, 32'h12345678, 8, 30, t);
        wait_neg(t + 1);
        chk("wrap_we", ram_we, 1);
        chk("wrap_addr", ram_addr, 3);

        // All four requesters valid continuously; the last grant went to 3.
        @(posedge clk); #1;
        set_req(0, LOAD, 7, 0, 255, 0);
        set_req(1, STORE, 10, 32'h11110000, 255, 0);
        set_req(2, NOP, 0, 0, 255, 0);
        set_req(3, LOADD, 3, 0, 255, 0);
        req_valid = '1;
        n_gr = 0;
        for (int k = 0; k < 100 && n_gr < 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    order[n_gr] = i;
                    n_gr++;
                end
            end
        end
        @(posedge clk); #1 req_valid = '0;
        chk("rr_count", n_gr, 5);
        chk("rr_0", order[0], 0);
        chk("rr_1", order[1], 1);
        chk("rr_2", order[2], 2);
        chk("rr_3", order[3], 3);
        chk("rr_4", order[4], 0);

        // Reset while a LOADD is in its DATA cycle.
        do_txn(2, LOADD, 3, 0, 255, 0, t);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("after_rst_we", ram_we, 0);
            chk("after_rst_resp", resp_valid, 0);
        end
        @(posedge clk); #1;
        set_req(0, LOAD, 3, 0, 255, 0);
        set_req(3, NOP, 0, 0, 255, 0);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 4'b0001);
        t = cyc;
        @(posedge clk); #1 req_valid[0] = 1'b0;
        // The word was 0x12345678 and one LOADD completed before the reset.
        wait_neg(t + 3);
        chk("post_rst_resp_valid", resp_valid, 4'b0001);
        chk("post_rst_word", resp_data, 32'h12345679);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[3]) break;
        end
        @(posedge clk); #1 req_valid = '0;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
